scalable_seq_generator: RTL

//  Serial transmitter for scalable_seq_detector: emits 2**STATE_BITS-bit pattern LSB (bit 0) first, one bit per accepted beat.

---
 rtl/scalable_seq_generator_pkg.sv | 24 ++
 rtl/scalable_seq_generator_if.sv | 33 +++
 rtl/scalable_seq_generator_gap_timer.sv | 39 +++
 rtl/scalable_seq_generator.sv | 117 +++++++++++
 4 files changed

// File: rtl/scalable_seq_generator_pkg.sv
// Shared types and helpers for the serial pattern generator:
// FSM state encoding, frame-length and gap-counter width functions.
package scalable_seq_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } gen_state_e;

    localparam int unsigned FRAME_CNT_W = 8;

    function automatic int unsigned pat_len(input int unsigned state_bits);
        return 32'd1 << state_bits;
    endfunction

    function automatic int unsigned gap_cnt_w(input int unsigned gap_cycles);
        int unsigned w;
        w = $clog2(gap_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/scalable_seq_generator_if.sv
// Control, status and valid/ready serial stream of the pattern generator.
// master = generator side, slave = controller/sink side.
interface scalable_seq_generator_if
    import scalable_seq_generator_pkg::*;
#(
    parameter int unsigned STATE_BITS = 3
) ();

    localparam int unsigned N = pat_len(STATE_BITS);

    logic                   go;
    logic                   abort;
    logic [N-1:0]           sequence_str;
    logic [FRAME_CNT_W-1:0] repeat_cnt;
    logic                   x;
    logic                   x_valid;
    logic                   x_ready;
    logic                   busy;
    logic                   done;
    logic [STATE_BITS-1:0]  bit_idx;
    logic [FRAME_CNT_W-1:0] frames_sent;

    modport master (
        input  go, abort, sequence_str, repeat_cnt, x_ready,
        output x, x_valid, busy, done, bit_idx, frames_sent
    );

    modport slave (
        output go, abort, sequence_str, repeat_cnt, x_ready,
        input  x, x_valid, busy, done, bit_idx, frames_sent
    );

endinterface

// File: rtl/scalable_seq_generator_gap_timer.sv
// Inter-frame idle timer: loads GAP_CYCLES-1 on entry to the gap and
// counts down; zero_o marks the final gap cycle.
module scalable_seq_generator_gap_timer
    import scalable_seq_generator_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic zero_o
);

    localparam int unsigned    W        = gap_cnt_w(GAP_CYCLES);
    localparam int unsigned    LOAD_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam logic [W-1:0]   LOAD_VAL = W'(LOAD_INT);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/scalable_seq_generator.sv
// Serial pattern transmitter: sends a 2**STATE_BITS-bit pattern LSB first
// over valid/ready, repeat_cnt+1 frames per burst with an optional idle gap.
module scalable_seq_generator
    import scalable_seq_generator_pkg::*;
#(
    parameter int unsigned STATE_BITS = 3,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                      clock0,
    input  logic                      reset,
    scalable_seq_generator_if.master  bus
);

    localparam int unsigned           N        = pat_len(STATE_BITS);
    localparam logic [STATE_BITS-1:0] LAST_IDX = STATE_BITS'(N - 1);

    gen_state_e             state_q, state_d;
    logic [N-1:0]           shreg_q, shreg_d;
    logic [STATE_BITS-1:0]  bit_idx_q, bit_idx_d;
    logic [FRAME_CNT_W-1:0] reps_left_q, reps_left_d;
    logic [FRAME_CNT_W-1:0] frames_q, frames_d;
    logic                   beat;
    logic                   gap_zero;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        reps_left_d = reps_left_q;
        frames_d    = frames_q;
        beat        = (state_q == ST_SEND) && bus.x_ready;

        if (bus.abort) begin
            // Abort beats everything, including a go arriving in IDLE.
            state_d   = ST_IDLE;
            bit_idx_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.go) begin
                        shreg_d     = bus.sequence_str;
                        reps_left_d = bus.repeat_cnt;
                        bit_idx_d   = '0;
                        frames_d    = '0;
                        state_d     = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (beat) begin
                        if (bit_idx_q == LAST_IDX) begin
                            bit_idx_d = '0;
                            frames_d  = frames_q + 8'd1;
                            if (reps_left_q == '0) begin
                                state_d = ST_DONE;
                            end else begin
                                reps_left_d = reps_left_q - 8'd1;
                                if (GAP_CYCLES > 0) begin
                                    state_d = ST_GAP;
                                end
                            end
                        end else begin
                            bit_idx_d = bit_idx_q + STATE_BITS'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_zero) begin
                        state_d = ST_SEND;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            reps_left_q <= '0;
            frames_q    <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            reps_left_q <= reps_left_d;
            frames_q    <= frames_d;
        end
    end

    if (GAP_CYCLES > 0) begin : g_gap
        scalable_seq_generator_gap_timer #(
            .GAP_CYCLES(GAP_CYCLES)
        ) u_gap_timer (
            .clk_i  (clock0),
            .rst_i  (reset),
            .load_i ((state_d == ST_GAP) && (state_q != ST_GAP)),
            .zero_o (gap_zero)
        );
    end else begin : g_no_gap
        assign gap_zero = 1'b1;
    end

    assign bus.x_valid     = (state_q == ST_SEND);
    assign bus.x           = bus.x_valid & shreg_q[bit_idx_q];
    assign bus.busy        = (state_q == ST_SEND) || (state_q == ST_GAP);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.bit_idx     = bit_idx_q;
    assign bus.frames_sent = frames_q;

endmodule
